// File: rtl/branch_predictor_pkg.sv
// Shared types and defaults for the branch predictor: counter encodings,
// table entry layout and default PC/index widths.
package branch_predictor_pkg;

    localparam int PC_W_DEF  = 13;
    localparam int IDX_W_DEF = 6;

    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } cnt_e;

    typedef struct packed {
        logic                          valid;
        logic [PC_W_DEF-IDX_W_DEF-1:0] tag;
        logic [PC_W_DEF-1:0]           target;
        cnt_e                          cnt;
    } bp_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating direction counter next-state logic; unconditional
// jumps force the strongly-taken state.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    input  logic       force_st_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (force_st_i) begin
            cnt_o = CNT_ST;
        end else if (taken_i) begin
            if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'd1;
        end else begin
            if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Define BP_BYPASS_EN to forward a same-cycle update to a colliding lookup.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic            CLK,
    input  logic            NRST,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_uncond,
    input  logic            flush
);

    localparam int TAG_W = PC_W - IDX_W;
    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [PC_W-1:0]  target_q [DEPTH];
    logic [1:0]       cnt_q    [DEPTH];

    logic [IDX_W-1:0] u_idx, l_idx;
    logic [TAG_W-1:0] u_tag, l_tag;

    assign u_idx = upd_pc[IDX_W-1:0];
    assign u_tag = upd_pc[PC_W-1:IDX_W];
    assign l_idx = lookup_pc[IDX_W-1:0];
    assign l_tag = lookup_pc[PC_W-1:IDX_W];

    logic             u_hit, wr_en;
    logic [TAG_W-1:0] tag_d;
    logic [PC_W-1:0]  target_d;
    logic [1:0]       cnt_d, cnt_sat;

    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    sat_counter2 u_sat (
        .cnt_i      (cnt_q[u_idx]),
        .taken_i    (upd_taken),
        .force_st_i (upd_uncond),
        .cnt_o      (cnt_sat)
    );

    // A not-taken miss leaves the table alone; flush suppresses any write.
    always_comb begin
        wr_en    = upd_en && !flush && (u_hit || upd_taken);
        tag_d    = u_tag;
        target_d = upd_taken ? upd_target : target_q[u_idx];
        if (u_hit) cnt_d = cnt_sat;
        else       cnt_d = upd_uncond ? CNT_ST : CNT_WT;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_valid
            assign valid_d[gi] = !flush &&
                (valid_q[gi] || (wr_en && (u_idx == IDX_W'(gi))));
        end
    endgenerate

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // Payload storage is not reset; it is only ever read behind a valid bit.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_q[u_idx]    <= tag_d;
            target_q[u_idx] <= target_d;
            cnt_q[u_idx]    <= cnt_d;
        end
    end

    logic             l_valid;
    logic [TAG_W-1:0] l_tag_s;
    logic [PC_W-1:0]  l_target_s;
    logic [1:0]       l_cnt_s;

    always_comb begin
        l_valid    = valid_q[l_idx];
        l_tag_s    = tag_q[l_idx];
        l_target_s = target_q[l_idx];
        l_cnt_s    = cnt_q[l_idx];
`ifdef BP_BYPASS_EN
        if (NRST && upd_en && (upd_pc == lookup_pc)) begin
            if (flush) begin
                l_valid = 1'b0;
            end else if (wr_en) begin
                l_valid    = 1'b1;
                l_tag_s    = tag_d;
                l_target_s = target_d;
                l_cnt_s    = cnt_d;
            end
        end
`endif
        pred_hit    = l_valid && (l_tag_s == l_tag);
        pred_taken  = pred_hit && l_cnt_s[1];
        pred_target = pred_taken ? l_target_s
                                 : lookup_pc + {{(PC_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed cases plus a random
// phase, expectations queued at drive time and compared when outputs settle.
module tb_branch_predictor;

    logic        CLK;
    logic        NRST;
    logic [12:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [12:0] pred_target;
    logic        upd_en;
    logic [12:0] upd_pc;
    logic        upd_taken;
    logic [12:0] upd_target;
    logic        upd_uncond;
    logic        flush;

    branch_predictor dut (
        .CLK         (CLK),
        .NRST        (NRST),
        .lookup_pc   (lookup_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_uncond  (upd_uncond),
        .flush       (flush)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        string       tag;
        logic [14:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    // Reference table state
    logic        m_valid [64];
    logic [6:0]  m_tag   [64];
    logic [12:0] m_tgt   [64];
    logic [1:0]  m_cnt   [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] mdl_lookup(input logic [12:0] pc);
        int          i;
        logic        hit;
        logic        tk;
        logic [12:0] tgt;
        i   = int'(pc[5:0]);
        hit = m_valid[i] && (m_tag[i] == pc[12:6]);
        tk  = hit && m_cnt[i][1];
        tgt = tk ? m_tgt[i] : pc + 13'd1;
        return {hit, tk, tgt};
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    task automatic mdl_update();
        int   i;
        logic hit;
        if (flush) begin
            mdl_clear();
        end else if (upd_en) begin
            i   = int'(upd_pc[5:0]);
            hit = m_valid[i] && (m_tag[i] == upd_pc[12:6]);
            if (hit) begin
                if (upd_taken) m_tgt[i] = upd_target;
                if (upd_uncond)                       m_cnt[i] = 2'd3;
                else if (upd_taken && m_cnt[i] != 2'd3)  m_cnt[i] = m_cnt[i] + 2'd1;
                else if (!upd_taken && m_cnt[i] != 2'd0) m_cnt[i] = m_cnt[i] - 2'd1;
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = upd_pc[12:6];
                m_tgt[i]   = upd_target;
                m_cnt[i]   = upd_uncond ? 2'd3 : 2'd2;
            end
        end
    endtask

    task automatic push_model(input string tag);
        logic [14:0] e;
        e = mdl_lookup(lookup_pc);
`ifdef BP_BYPASS_EN
        if (NRST && upd_en && (upd_pc == lookup_pc)) begin
            int          i;
            logic        sv_v;
            logic [6:0]  sv_t;
            logic [12:0] sv_g;
            logic [1:0]  sv_c;
            logic        sv_all [64];
            i    = int'(upd_pc[5:0]);
            sv_v = m_valid[i]; sv_t = m_tag[i]; sv_g = m_tgt[i]; sv_c = m_cnt[i];
            for (int k = 0; k < 64; k++) sv_all[k] = m_valid[k];
            mdl_update();
            e = mdl_lookup(lookup_pc);
            for (int k = 0; k < 64; k++) m_valid[k] = sv_all[k];
            m_valid[i] = sv_v; m_tag[i] = sv_t; m_tgt[i] = sv_g; m_cnt[i] = sv_c;
        end
`endif
        sb_q.push_back('{tag: {tag, "_mdl"}, exp: e});
    endtask

    task automatic expect_const(input string tag, input logic [14:0] e);
        sb_q.push_back('{tag: tag, exp: e});
    endtask

    task automatic compare_pending();
        sb_item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            chk(it.tag, {17'd0, pred_hit, pred_taken, pred_target}, {17'd0, it.exp});
        end
    endtask

    task automatic drive(input logic ue, input logic [12:0] upc, input logic tk,
                         input logic [12:0] tgt, input logic unc, input logic fl,
                         input logic [12:0] lpc, input string tag);
        upd_en     = ue;
        upd_pc     = upc;
        upd_taken  = tk;
        upd_target = tgt;
        upd_uncond = unc;
        flush      = fl;
        lookup_pc  = lpc;
        push_model(tag);
    endtask

    task automatic settle();
        @(negedge CLK);
        cyc++;
        $display("cyc %0d upd=%b pc=%h tk=%b fl=%b lk=%h -> hit=%b tk=%b tgt=%h",
                 cyc, upd_en, upd_pc, upd_taken, flush, lookup_pc,
                 pred_hit, pred_taken, pred_target);
        compare_pending();
        @(posedge CLK);
        if (NRST) mdl_update();
        #1;
        upd_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic look(input logic [12:0] lpc, input logic [14:0] e, input string tag);
        drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 1'b0, lpc, tag);
        expect_const(tag, e);
        settle();
    endtask

    task automatic upd(input logic [12:0] upc, input logic tk, input logic [12:0] tgt,
                       input logic unc, input string tag);
        drive(1'b1, upc, tk, tgt, unc, 1'b0, 13'h1abc, tag);
        settle();
    endtask

    initial begin
        logic [1:0] rt, ri, lt, li;
        NRST = 1'b0;
        mdl_clear();
        drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 1'b0, 13'h0040, "rst");
        #2;
        expect_const("rst_state", {1'b0, 1'b0, 13'h0041});
        compare_pending();
        repeat (2) @(posedge CLK);
        #1 NRST = 1'b1;

        look(13'h0040, {1'b0, 1'b0, 13'h0041}, "cold_miss");

        drive(1'b1, 13'h0040, 1'b1, 13'h0100, 1'b0, 1'b0, 13'h1fff, "wrap");
        expect_const("wrap", {1'b0, 1'b0, 13'h0000});
        settle();
        look(13'h0040, {1'b1, 1'b1, 13'h0100}, "alloc_wt");

        upd(13'h0040, 1'b0, 13'h0, 1'b0, "nt1");
        look(13'h0040, {1'b1, 1'b0, 13'h0041}, "wnt");
        upd(13'h0040, 1'b0, 13'h0, 1'b0, "nt2");
        look(13'h0040, {1'b1, 1'b0, 13'h0041}, "snt");
        upd(13'h0040, 1'b0, 13'h0, 1'b0, "nt3");
        upd(13'h0040, 1'b1, 13'h0123, 1'b0, "t_from_snt");
        look(13'h0040, {1'b1, 1'b0, 13'h0041}, "sat_low");
        upd(13'h0040, 1'b1, 13'h0124, 1'b0, "t_to_wt");
        look(13'h0040, {1'b1, 1'b1, 13'h0124}, "wt_again");

        upd(13'h0040, 1'b1, 13'h0125, 1'b1, "uncond_st");
        upd(13'h0040, 1'b1, 13'h0125, 1'b0, "t_at_st");
        look(13'h0040, {1'b1, 1'b1, 13'h0125}, "sat_high");
        upd(13'h0040, 1'b0, 13'h0, 1'b0, "st_nt");
        look(13'h0040, {1'b1, 1'b1, 13'h0125}, "st_to_wt");

        upd(13'h0080, 1'b1, 13'h0055, 1'b0, "conflict");
        look(13'h0040, {1'b0, 1'b0, 13'h0041}, "evicted");
        look(13'h0080, {1'b1, 1'b1, 13'h0055}, "new_owner");

        upd(13'h00c5, 1'b1, 13'h0300, 1'b1, "jal_alloc");
        look(13'h00c5, {1'b1, 1'b1, 13'h0300}, "jal_hit");
        upd(13'h00c5, 1'b0, 13'h0777, 1'b0, "jal_nt");
        look(13'h00c5, {1'b1, 1'b1, 13'h0300}, "keep_tgt");

        upd(13'h0007, 1'b0, 13'h0333, 1'b0, "nt_miss");
        look(13'h0007, {1'b0, 1'b0, 13'h0008}, "no_alloc");

        drive(1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 1'b1, 13'h0080, "flush");
        settle();
        look(13'h0080, {1'b0, 1'b0, 13'h0081}, "flushed");
        drive(1'b1, 13'h0040, 1'b1, 13'h0200, 1'b0, 1'b0, 13'h0040, "collide");
`ifdef BP_BYPASS_EN
        expect_const("collide", {1'b1, 1'b1, 13'h0200});
`else
        expect_const("collide", {1'b0, 1'b0, 13'h0041});
`endif
        settle();
        look(13'h0040, {1'b1, 1'b1, 13'h0200}, "after_collide");

        drive(1'b1, 13'h0009, 1'b1, 13'h0010, 1'b0, 1'b1, 13'h0040, "flush_upd");
        settle();
        look(13'h0009, {1'b0, 1'b0, 13'h000a}, "flush_wins");
        look(13'h0040, {1'b0, 1'b0, 13'h0041}, "flush_all");

        for (int n = 0; n < 300; n++) begin
            rt = 2'($urandom_range(0, 3)); ri = 2'($urandom_range(0, 3));
            lt = 2'($urandom_range(0, 3)); li = 2'($urandom_range(0, 3));
            drive(($urandom_range(0, 3) != 0),
                  {5'd0, rt, 4'd0, ri}, 1'($urandom_range(0, 1)),
                  13'($urandom_range(0, 8191)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 40) == 0),
                  {5'd0, lt, 4'd0, li}, "rand");
            settle();
        end

        upd(13'h0040, 1'b1, 13'h0abc, 1'b0, "pre_rst");
        look(13'h0040, {1'b1, 1'b1, 13'h0abc}, "pre_rst_hit");
        lookup_pc = 13'h0040;
        #2 NRST = 1'b0;
        mdl_clear();
        #1;
        expect_const("async_rst", {1'b0, 1'b0, 13'h0041});
        compare_pending();
        drive(1'b1, 13'h0011, 1'b1, 13'h0222, 1'b0, 1'b0, 13'h0011, "upd_in_rst");
        expect_const("upd_in_rst", {1'b0, 1'b0, 13'h0012});
        settle();
        NRST = 1'b1;
        look(13'h0011, {1'b0, 1'b0, 13'h0012}, "rst_discard");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
